ttt_processor: RTL
==================

TTT_PROCESSOR -- requirements
Module: ttt_processor

Interface
REQ-001 SHALL have parameter NEW_TOKENS_BITS, default 4: width of each per-cycle token input.
REQ-002 SHALL have parameter TOKEN_BITS, default 8: width of the signed token accumulator.
REQ-003 SHALL have parameter DURATION_BITS, default 8: width of the duration input and the down-counter.
REQ-004 SHALL have port clk  input  1  the single clock; all state rising-edge triggered.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-006 SHALL have port enable  input  1  token-update strobe; inputs sampled only when high.
REQ-007 SHALL have port new_good_tokens  input  NEW_TOKENS_BITS  unsigned count of tokens to add.
REQ-008 SHALL have port new_bad_tokens  input  NEW_TOKENS_BITS  unsigned count of tokens to subtract.
REQ-009 SHALL have port threshold  input  TOKEN_BITS  signed firing threshold, quasi-static.
REQ-010 SHALL have port duration  input  DURATION_BITS  unsigned active-period length in cycles, quasi-static.
REQ-011 SHALL have port tstartstop  output  2  bit0 = tstart pulse, bit1 = tstop pulse.
REQ-012 SHALL have port token_count  output  TOKEN_BITS  signed accumulator value, registered.
REQ-013 SHALL have port active  output  1  high while in ACTIVE.

Function
REQ-014 On a clock edge with enable=1, token_count SHALL become sat(token_count + new_good_tokens - new_bad_tokens), saturating to [-2^(TOKEN_BITS-1), 2^(TOKEN_BITS-1)-1]; computed at TOKEN_BITS+1 width.
REQ-015 Good and bad tokens in the same cycle SHALL net; equal values leave token_count unchanged.
REQ-016 States SHALL be IDLE, ACTIVE, plus REFRACTORY when REQ-028 is enabled.
REQ-017 IDLE -> ACTIVE when enable=1 and the updated count >= threshold; tstartstop[0] SHALL be high for exactly the one cycle following that edge; the counter loads duration.
REQ-018 In ACTIVE the counter SHALL decrement by 1 per cycle; tokens keep accumulating; no further tstart is issued.
REQ-019 ACTIVE SHALL exit when counter == 0 (expiry) or the registered token_count < threshold (drop-out); tstartstop[1] SHALL be high for exactly the one cycle after the exit edge.
REQ-020 On expiry token_count SHALL clear to 0; tokens arriving on that edge SHALL be added to 0. On drop-out token_count SHALL be kept.
REQ-021 duration = 0 SHALL give tstart in cycle N+1 and tstop in cycle N+2.
REQ-022 tstart and tstop SHALL never be high in the same cycle; active SHALL be high from the tstart cycle through the cycle before tstop.

Reset
REQ-023 While rst_n=0: state IDLE, counter 0, token_count 0, tstartstop 2'b00, active 0.
REQ-024 Reset asserted mid-ACTIVE SHALL abort immediately with no tstop emitted.
REQ-025 The first enable edge after rst_n deassertion SHALL be processed normally.

Configuration
REQ-026 Macro TTT_PROCESSOR_REFRACTORY_EN SHALL control the refractory feature.
REQ-027 Without the macro, every ACTIVE exit SHALL go to IDLE, and IDLE SHALL re-evaluate on the next enable edge.
REQ-028 With the macro, every ACTIVE exit SHALL go to REFRACTORY for REFRACTORY_CYCLES (parameter, default 4) cycles, accumulating tokens without firing, then go to IDLE; firing SHALL need a fresh enable edge in IDLE.

Structure
REQ-029 Package ttt_pkg SHALL hold the state enum type and the default width constants; the network block SHALL use the same constants.
REQ-030 Saturating add/subtract SHALL be a sub-module, ttt_sat_accum (combinational, parameterised by widths).

Verification
REQ-031 Bench scenarios, defaults, threshold=5, duration=3:
- enable, good=3 twice -> count 3 then 6; tstart one cycle after 2nd edge; tstop 4 cycles after tstart; count 0.
- In ACTIVE with count 6: enable, bad=4 -> count 2; tstop next cycle; count stays 2.
- good=7, bad=7, enable -> count unchanged, no pulses.
- count 120, good=15 repeatedly -> count saturates at 127; count -120, bad=15 -> -128.
- rst_n low mid-ACTIVE -> all outputs 0, no tstop; duration=0 -> tstart then tstop on consecutive cycles.
- Macro on: threshold reached during REFRACTORY -> no tstart until 4 cycles elapse and next enable edge.

Source files
------------

// File: rtl/ttt_pkg.sv
// Shared width defaults and FSM state type for the TTT processor.
// Defining TTT_PROCESSOR_REFRACTORY_EN adds the REFRACTORY state and its default length.
package ttt_pkg;

  localparam int DEF_NEW_TOKENS_BITS = 4;
  localparam int DEF_TOKEN_BITS      = 8;
  localparam int DEF_DURATION_BITS   = 8;

`ifdef TTT_PROCESSOR_REFRACTORY_EN
  localparam int DEF_REFRACTORY_CYCLES = 4;
`endif

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1
`ifdef TTT_PROCESSOR_REFRACTORY_EN
    , REFRACTORY = 2'd2
`endif
  } state_t;

endpackage

// File: rtl/ttt_sat_accum.sv
// Combinational saturating accumulate: acc + add_tokens - sub_tokens, clamped to the
// signed TOKEN_BITS range. Token inputs must be narrower than the accumulator.
module ttt_sat_accum
  import ttt_pkg::*;
#(
  parameter int NEW_TOKENS_BITS = DEF_NEW_TOKENS_BITS,
  parameter int TOKEN_BITS      = DEF_TOKEN_BITS
) (
  input  logic signed [TOKEN_BITS-1:0]      acc,
  input  logic        [NEW_TOKENS_BITS-1:0] add_tokens,
  input  logic        [NEW_TOKENS_BITS-1:0] sub_tokens,
  output logic signed [TOKEN_BITS-1:0]      result
);

  localparam int WIDE_BITS = TOKEN_BITS + 1;

  logic signed [WIDE_BITS-1:0] acc_wide;
  logic signed [WIDE_BITS-1:0] add_wide;
  logic signed [WIDE_BITS-1:0] sub_wide;
  logic signed [WIDE_BITS-1:0] sum_wide;

  assign acc_wide = {acc[TOKEN_BITS-1], acc};
  assign add_wide = {{(WIDE_BITS-NEW_TOKENS_BITS){1'b0}}, add_tokens};
  assign sub_wide = {{(WIDE_BITS-NEW_TOKENS_BITS){1'b0}}, sub_tokens};
  assign sum_wide = acc_wide + add_wide - sub_wide;

  // One guard bit is enough: a disagreeing top pair means the true sum left the range.
  always_comb begin
    result = sum_wide[TOKEN_BITS-1:0];
    if (sum_wide[WIDE_BITS-1] != sum_wide[TOKEN_BITS-1]) begin
      if (sum_wide[WIDE_BITS-1]) begin
        result = {1'b1, {(TOKEN_BITS-1){1'b0}}};
      end else begin
        result = {1'b0, {(TOKEN_BITS-1){1'b1}}};
      end
    end
  end

endmodule

// File: rtl/ttt_processor.sv
// Token-threshold trigger: accumulates good/bad tokens and fires a timed active window.
// Defining TTT_PROCESSOR_REFRACTORY_EN inserts a REFRACTORY hold-off after each window.
module ttt_processor
  import ttt_pkg::*;
#(
  parameter int NEW_TOKENS_BITS = DEF_NEW_TOKENS_BITS,
  parameter int TOKEN_BITS      = DEF_TOKEN_BITS,
  parameter int DURATION_BITS   = DEF_DURATION_BITS
`ifdef TTT_PROCESSOR_REFRACTORY_EN
  , parameter int REFRACTORY_CYCLES = DEF_REFRACTORY_CYCLES
`endif
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              enable,
  input  logic        [NEW_TOKENS_BITS-1:0] new_good_tokens,
  input  logic        [NEW_TOKENS_BITS-1:0] new_bad_tokens,
  input  logic signed [TOKEN_BITS-1:0]      threshold,
  input  logic        [DURATION_BITS-1:0]   duration,
  output logic        [1:0]                 tstartstop,
  output logic signed [TOKEN_BITS-1:0]      token_count,
  output logic                              active
);

`ifdef TTT_PROCESSOR_REFRACTORY_EN
  localparam logic [DURATION_BITS-1:0] REFRACTORY_LOAD = DURATION_BITS'(REFRACTORY_CYCLES - 1);
`endif

  state_t                       state;
  logic [DURATION_BITS-1:0]     counter;
  logic                         expiry;
  logic                         dropout;
  logic signed [TOKEN_BITS-1:0] accum_base;
  logic signed [TOKEN_BITS-1:0] accum_sum;
  logic signed [TOKEN_BITS-1:0] next_count;

  assign expiry  = (state == ACTIVE) && (counter == '0);
  assign dropout = (state == ACTIVE) && (token_count < threshold);

  // Expiry wins over drop-out, so tokens arriving on the expiry edge land on a cleared count.
  assign accum_base = expiry ? '0 : token_count;

  ttt_sat_accum #(
    .NEW_TOKENS_BITS(NEW_TOKENS_BITS),
    .TOKEN_BITS     (TOKEN_BITS)
  ) u_sat_accum (
    .acc       (accum_base),
    .add_tokens(new_good_tokens),
    .sub_tokens(new_bad_tokens),
    .result    (accum_sum)
  );

  assign next_count = enable ? accum_sum : accum_base;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      counter     <= '0;
      token_count <= '0;
      tstartstop  <= 2'b00;
      active      <= 1'b0;
    end else begin
      token_count <= next_count;
      tstartstop  <= 2'b00;
      case (state)
        IDLE: begin
          if (enable && (next_count >= threshold)) begin
            state      <= ACTIVE;
            counter    <= duration;
            tstartstop <= 2'b01;
            active     <= 1'b1;
          end
        end
        ACTIVE: begin
          if (expiry || dropout) begin
            tstartstop <= 2'b10;
            active     <= 1'b0;
`ifdef TTT_PROCESSOR_REFRACTORY_EN
            state      <= REFRACTORY;
            counter    <= REFRACTORY_LOAD;
`else
            state      <= IDLE;
`endif
          end else begin
            counter <= counter - DURATION_BITS'(1);
          end
        end
`ifdef TTT_PROCESSOR_REFRACTORY_EN
        // Tokens keep accumulating here, but firing waits for an enable edge back in IDLE.
        REFRACTORY: begin
          if (counter == '0) begin
            state <= IDLE;
          end else begin
            counter <= counter - DURATION_BITS'(1);
          end
        end
`endif
        default: begin
          state  <= IDLE;
          active <= 1'b0;
        end
      endcase
    end
  end

endmodule
